// File: rtl/turn_scheduler.sv
// ---------------------------------------------------------------------------
// turn_scheduler
//   Two-player turn scheduler in front of a shared guess datapath. The active
//   player's switch bank is latched and presented to the datapath for one
//   guess per turn; turns expire after TURN_TICKS cycles. Per-player scores
//   saturate, and a winner is declared once the datapath reports the board as
//   solved.
//
// Optional feature macro: STREAK_BONUS_EN
//   defined   : a correct guess keeps the turn; an incorrect guess passes it.
//   undefined : the turn passes after every guess.
//   A timeout always passes the turn.
//
// Ports
//   i_clk            system clock
//   i_reset          synchronous, active-low reset
//   i_start          level; a rising edge in IDLE or DONE starts a game
//   i_abort          level; returns to IDLE at the next edge
//   i_guess_a        player A switch bank
//   i_guess_b        player B switch bank
//   i_is_correct     datapath result, valid RESULT_LAT cycles after issue
//   i_is_solved      datapath board-solved flag
//   o_guess_out      guess to datapath, zero outside ISSUE/RESULT
//   o_active_player  0 = A, 1 = B
//   o_score_a        player A score
//   o_score_b        player B score
//   o_turn_timeout   one-cycle pulse when a turn expires
//   o_game_done      high while in DONE
//   o_winner         00 none, 01 A, 10 B, 11 tie (valid while o_game_done)
// ---------------------------------------------------------------------------
module turn_scheduler #(
    parameter int WIDTH      = 8,
    parameter int SCORE_W    = 4,
    parameter int TURN_TICKS = 50000000,
    parameter int RESULT_LAT = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [WIDTH-1:0]   i_guess_a,
    input  logic [WIDTH-1:0]   i_guess_b,
    input  logic               i_is_correct,
    input  logic               i_is_solved,
    output logic [WIDTH-1:0]   o_guess_out,
    output logic               o_active_player,
    output logic [SCORE_W-1:0] o_score_a,
    output logic [SCORE_W-1:0] o_score_b,
    output logic               o_turn_timeout,
    output logic               o_game_done,
    output logic [1:0]         o_winner
);

    localparam int TW = $clog2(TURN_TICKS);
    localparam int LW = $clog2(RESULT_LAT + 1);
    localparam logic [TW-1:0]      TIMER_LOAD = TW'(TURN_TICKS - 1);
    localparam logic [LW-1:0]      LAT_LOAD   = LW'(RESULT_LAT - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_TURN,
        S_ISSUE,
        S_RESULT,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [TW-1:0]      r_timer;
    logic [LW-1:0]      r_lat;
    logic               r_sample;
    logic [WIDTH-1:0]   r_guess;
    logic               r_active;
    logic [SCORE_W-1:0] r_score_a;
    logic [SCORE_W-1:0] r_score_b;
    logic               r_timeout;
    logic               r_done;
    logic [1:0]         r_winner;
    logic               r_start_q;

    state_t             w_state_next;
    logic [TW-1:0]      w_timer_next;
    logic [LW-1:0]      w_lat_next;
    logic               w_sample_next;
    logic [WIDTH-1:0]   w_guess_next;
    logic               w_active_next;
    logic [SCORE_W-1:0] w_score_a_next;
    logic [SCORE_W-1:0] w_score_b_next;
    logic               w_timeout_next;
    logic               w_done_next;
    logic [1:0]         w_winner_next;

    logic               w_start_rise;
    logic [WIDTH-1:0]   w_active_bank;
    logic [1:0]         w_winner_calc;

    // The inactive bank never reaches the datapath.
    assign w_start_rise  = i_start & ~r_start_q;
    assign w_active_bank = r_active ? i_guess_b : i_guess_a;
    assign w_winner_calc = (r_score_a > r_score_b) ? 2'b01 :
                           (r_score_b > r_score_a) ? 2'b10 : 2'b11;

    // Next-state and next-output logic. Every output is registered, so the
    // values computed here are what the outputs show in the next state.
    // The guess register doubles as o_guess_out: it is loaded on entry to
    // ISSUE and cleared on the way out of RESULT, so it is zero elsewhere.
    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = r_timer;
        w_lat_next     = r_lat;
        w_sample_next  = r_sample;
        w_guess_next   = r_guess;
        w_active_next  = r_active;
        w_score_a_next = r_score_a;
        w_score_b_next = r_score_b;
        w_timeout_next = 1'b0;
        w_done_next    = 1'b0;
        w_winner_next  = 2'b00;

        if (i_abort) begin
            w_state_next = S_IDLE;
            w_guess_next = '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_rise) begin
                        w_score_a_next = '0;
                        w_score_b_next = '0;
                        w_active_next  = 1'b0;
                        w_state_next   = S_ARM;
                    end
                end
                S_ARM: begin
                    // A bank still nonzero here is a guess carried over from
                    // the previous turn; wait until the switches are cleared.
                    if (i_is_solved) begin
                        w_state_next = S_DONE;
                    end else if (w_active_bank == '0) begin
                        w_timer_next = TIMER_LOAD;
                        w_state_next = S_TURN;
                    end
                end
                S_TURN: begin
                    if (r_timer != '0) begin
                        w_timer_next = r_timer - TW'(1);
                    end
                    // A guess in the last cycle of the turn beats the timeout.
                    if (w_active_bank != '0) begin
                        w_guess_next = w_active_bank;
                        w_state_next = S_ISSUE;
                    end else if (r_timer == '0) begin
                        w_timeout_next = 1'b1;
                        w_active_next  = ~r_active;
                        w_state_next   = S_ARM;
                    end
                end
                S_ISSUE: begin
                    w_lat_next   = LAT_LOAD;
                    w_state_next = S_RESULT;
                end
                S_RESULT: begin
                    if (r_lat == '0) begin
                        w_sample_next = i_is_correct;
                        w_guess_next  = '0;
                        w_state_next  = S_UPDATE;
                    end else begin
                        w_lat_next = r_lat - LW'(1);
                    end
                end
                S_UPDATE: begin
                    if (r_sample) begin
                        if (r_active) begin
                            if (r_score_b != SCORE_MAX) w_score_b_next = r_score_b + SCORE_W'(1);
                        end else begin
                            if (r_score_a != SCORE_MAX) w_score_a_next = r_score_a + SCORE_W'(1);
                        end
                    end
`ifdef STREAK_BONUS_EN
                    if (!r_sample) w_active_next = ~r_active;
`else
                    w_active_next = ~r_active;
`endif
                    w_state_next = S_ARM;
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_guess_next = '0;
                end
            endcase
        end

        // The winner is frozen from the final scores on entry to DONE.
        w_done_next = (w_state_next == S_DONE);
        if (w_state_next == S_DONE) begin
            w_winner_next = (r_state == S_DONE) ? r_winner : w_winner_calc;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state   <= S_IDLE;
            r_timer   <= TIMER_LOAD;
            r_lat     <= '0;
            r_sample  <= 1'b0;
            r_guess   <= '0;
            r_active  <= 1'b0;
            r_score_a <= '0;
            r_score_b <= '0;
            r_timeout <= 1'b0;
            r_done    <= 1'b0;
            r_winner  <= 2'b00;
            r_start_q <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_lat     <= w_lat_next;
            r_sample  <= w_sample_next;
            r_guess   <= w_guess_next;
            r_active  <= w_active_next;
            r_score_a <= w_score_a_next;
            r_score_b <= w_score_b_next;
            r_timeout <= w_timeout_next;
            r_done    <= w_done_next;
            r_winner  <= w_winner_next;
            r_start_q <= i_start;
        end
    end

    assign o_guess_out     = r_guess;
    assign o_active_player = r_active;
    assign o_score_a       = r_score_a;
    assign o_score_b       = r_score_b;
    assign o_turn_timeout  = r_timeout;
    assign o_game_done     = r_done;
    assign o_winner        = r_winner;

endmodule

// File: tb/tb_turn_scheduler.sv
// ---------------------------------------------------------------------------
// tb_turn_scheduler
//   Self-checking bench for turn_scheduler with a short turn (8 ticks), a
//   two-cycle result latency and 2-bit saturating scores. Guess turns come
//   from a table; each driven turn pushes its expected guess and post-turn
//   scores/player onto a queue that a negedge monitor pops as the DUT
//   completes the guess. Timeouts, game end, restart, abort and reset are
//   covered by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_turn_scheduler;

    localparam int TT = 8;
    localparam int RL = 2;
    localparam int SW = 2;
    localparam logic [SW-1:0] SMAX = '1;
    localparam int NVEC = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic [7:0]    guessA;
    logic [7:0]    guessB;
    logic          isCorrect;
    logic          isSolved;
    logic [7:0]    guessOut;
    logic          activePlayer;
    logic [SW-1:0] scoreA;
    logic [SW-1:0] scoreB;
    logic          turnTimeout;
    logic          gameDone;
    logic [1:0]    winner;

    turn_scheduler #(
        .WIDTH      (8),
        .SCORE_W    (SW),
        .TURN_TICKS (TT),
        .RESULT_LAT (RL)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_start         (start),
        .i_abort         (abort),
        .i_guess_a       (guessA),
        .i_guess_b       (guessB),
        .i_is_correct    (isCorrect),
        .i_is_solved     (isSolved),
        .o_guess_out     (guessOut),
        .o_active_player (activePlayer),
        .o_score_a       (scoreA),
        .o_score_b       (scoreB),
        .o_turn_timeout  (turnTimeout),
        .o_game_done     (gameDone),
        .o_winner        (winner)
    );

    typedef struct {
        logic          newGame;
        logic [7:0]    guess;
        logic [7:0]    noise;
        logic          correct;
        logic          player;
        logic [SW-1:0] expA;
        logic [SW-1:0] expB;
        logic          expAct;
    } turnVec_t;

    typedef struct {
        logic [7:0]    guess;
        logic [SW-1:0] expA;
        logic [SW-1:0] expB;
        logic          expAct;
    } sbItem_t;

    turnVec_t tbl [NVEC];
    sbItem_t  sbQueue [$];
    sbItem_t  curExp;

    int checks = 0;
    int failures = 0;
    int doneTurns = 0;
    int runLen = 0;
    bit monEn = 0;
    bit pendingArm = 0;
    logic [7:0] runGuess;

    logic [SW-1:0] mA;
    logic [SW-1:0] mB;
    logic          mAct;
    int            cnt;
    bit            sawGuess;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic turnVec_t mkVec(input logic ng, input logic [7:0] g, input logic [7:0] n, input logic c);
        turnVec_t v;
        v.newGame = ng;
        v.guess   = g;
        v.noise   = n;
        v.correct = c;
        v.player  = 1'b0;
        v.expA    = '0;
        v.expB    = '0;
        v.expAct  = 1'b0;
        return v;
    endfunction

    function automatic logic [1:0] winnerOf(input logic [SW-1:0] a, input logic [SW-1:0] b);
        if (a > b) return 2'b01;
        if (b > a) return 2'b10;
        return 2'b11;
    endfunction

    // One full guess turn. Banks are cleared for two cycles so the DUT is in
    // TURN, then the active bank is driven. is_correct carries the wanted
    // value only in the final RESULT cycle and the opposite value elsewhere.
    task automatic applyStimulus(input turnVec_t v);
        sbItem_t it;
        int startCount;
        guessA = '0;
        guessB = '0;
        isCorrect = ~v.correct;
        tick();
        tick();
        it.guess  = v.guess;
        it.expA   = v.expA;
        it.expB   = v.expB;
        it.expAct = v.expAct;
        sbQueue.push_back(it);
        if (v.player) begin
            guessB = v.guess;
            guessA = v.noise;
        end else begin
            guessA = v.guess;
            guessB = v.noise;
        end
        tick();
        tick();
        tick();
        isCorrect = v.correct;
        tick();
        isCorrect = ~v.correct;
        startCount = doneTurns;
        for (int k = 0; k < 20 && doneTurns == startCount; k++) tick();
        checkOutput("turn_complete", doneTurns - startCount, 1);
    endtask

    // Scoreboard monitor: measures each nonzero guess_out run, and one cycle
    // after it ends (first ARM cycle) checks the updated scores and player.
    always @(negedge clk) begin
        if (!reset || !monEn) begin
            runLen = 0;
            pendingArm = 0;
        end else if (guessOut != '0) begin
            if (runLen == 0) runGuess = guessOut;
            runLen++;
        end else if (runLen != 0) begin
            if (sbQueue.size() == 0) begin
                checkOutput("sb_unexpected_guess", runGuess, 8'h00);
            end else begin
                curExp = sbQueue.pop_front();
                checkOutput("sb_guess", runGuess, curExp.guess);
                checkOutput("sb_guess_len", runLen, 1 + RL);
                pendingArm = 1;
            end
            runLen = 0;
        end else if (pendingArm) begin
            checkOutput("sb_score_a", scoreA, curExp.expA);
            checkOutput("sb_score_b", scoreB, curExp.expB);
            checkOutput("sb_active", activePlayer, curExp.expAct);
            pendingArm = 0;
            doneTurns++;
        end
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        guessA = '0;
        guessB = '0;
        isCorrect = 1'b0;
        isSolved = 1'b0;

        // Turn table: games start at entries 0, 10, 14 and 15.
        tbl[0]  = mkVec(1, 8'h04, 8'hFF, 1);
        tbl[1]  = mkVec(0, 8'h10, 8'h5A, 0);
        tbl[2]  = mkVec(0, 8'h81, 8'h00, 1);
        tbl[3]  = mkVec(0, 8'h22, 8'h77, 1);
        tbl[4]  = mkVec(0, 8'h01, 8'h80, 1);
        tbl[5]  = mkVec(0, 8'hF0, 8'h0F, 0);
        tbl[6]  = mkVec(0, 8'h02, 8'h40, 1);
        tbl[7]  = mkVec(0, 8'h03, 8'hC3, 1);
        tbl[8]  = mkVec(0, 8'h55, 8'h33, 1);
        tbl[9]  = mkVec(0, 8'hAA, 8'h11, 0);
        tbl[10] = mkVec(1, 8'h08, 8'h99, 0);
        tbl[11] = mkVec(0, 8'h60, 8'h06, 1);
        tbl[12] = mkVec(0, 8'h0C, 8'hE0, 1);
        tbl[13] = mkVec(0, 8'h7E, 8'h01, 1);
        tbl[14] = mkVec(1, 8'h21, 8'h12, 1);
        tbl[15] = mkVec(1, 8'h44, 8'h00, 1);

        // Behavioural scoring model fills the expected columns.
        mA = '0;
        mB = '0;
        mAct = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            if (tbl[i].newGame) begin
                mA = '0;
                mB = '0;
                mAct = 1'b0;
            end
            tbl[i].player = mAct;
            if (tbl[i].correct) begin
                if (mAct) begin
                    if (mB != SMAX) mB = mB + 1'b1;
                end else begin
                    if (mA != SMAX) mA = mA + 1'b1;
                end
            end
`ifdef STREAK_BONUS_EN
            if (!tbl[i].correct) mAct = ~mAct;
`else
            mAct = ~mAct;
`endif
            tbl[i].expA = mA;
            tbl[i].expB = mB;
            tbl[i].expAct = mAct;
        end

        // Reset state.
        tick();
        tick();
        checkOutput("reset_guess_out", guessOut, 0);
        checkOutput("reset_active", activePlayer, 0);
        checkOutput("reset_scores", {scoreA, scoreB}, 0);
        checkOutput("reset_timeout", turnTimeout, 0);
        checkOutput("reset_done_winner", {gameDone, winner}, 0);
        reset = 1'b1;
        tick();

        // Game 1: A's turn expires while B's bank shows 8'hFF.
        guessA = '0;
        guessB = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start_active", activePlayer, 0);
        cnt = 0;
        sawGuess = 0;
        // Sampling starts in ARM; TURN is entered one edge later.
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (guessOut != '0) sawGuess = 1;
            if (turnTimeout) begin
                cnt = k;
                break;
            end
        end
        checkOutput("timeout_a_latency", cnt, TT + 1);
        checkOutput("timeout_a_no_guess", sawGuess, 0);
        checkOutput("timeout_a_player", activePlayer, 1);
        checkOutput("timeout_a_scores", {scoreA, scoreB}, 0);

        // B's turn expires while A's bank shows 8'hFF.
        guessA = 8'hFF;
        guessB = '0;
        cnt = 0;
        sawGuess = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (guessOut != '0) sawGuess = 1;
            if (turnTimeout) begin
                cnt = k;
                break;
            end
        end
        checkOutput("timeout_b_latency", cnt, TT + 1);
        checkOutput("timeout_b_no_guess", sawGuess, 0);
        checkOutput("timeout_b_player", activePlayer, 0);
        checkOutput("timeout_b_scores", {scoreA, scoreB}, 0);
        tick();
        checkOutput("timeout_pulse_width", turnTimeout, 0);

        monEn = 1;
        for (int i = 0; i < 10; i++) applyStimulus(tbl[i]);

        // Board solved: game 1 ends.
        guessA = '0;
        guessB = '0;
        isSolved = 1'b1;
        for (int k = 0; k < 40 && !gameDone; k++) tick();
        checkOutput("g1_done", gameDone, 1);
        checkOutput("g1_winner", winner, winnerOf(tbl[9].expA, tbl[9].expB));
        checkOutput("g1_score_a", scoreA, tbl[9].expA);
        checkOutput("g1_score_b", scoreB, tbl[9].expB);
        tick();
        checkOutput("g1_done_holds", {gameDone, scoreA, scoreB}, {1'b1, tbl[9].expA, tbl[9].expB});

        // Game 2 started from DONE.
        isSolved = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("g2_start_done", gameDone, 0);
        checkOutput("g2_start_scores", {scoreA, scoreB}, 0);
        for (int i = 10; i < 14; i++) applyStimulus(tbl[i]);
        guessA = '0;
        guessB = '0;
        isSolved = 1'b1;
        for (int k = 0; k < 40 && !gameDone; k++) tick();
        checkOutput("g2_done", gameDone, 1);
        checkOutput("g2_winner", winner, winnerOf(tbl[13].expA, tbl[13].expB));

        // Restart with the board still solved, then hold start high.
        start = 1'b1;
        tick();
        checkOutput("restart_in_arm", gameDone, 0);
        checkOutput("restart_scores", {scoreA, scoreB}, 0);
        tick();
        checkOutput("restart_done_again", gameDone, 1);
        checkOutput("restart_tie", winner, 2'b11);
        sawGuess = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (!gameDone) sawGuess = 1;
        end
        checkOutput("start_held_no_restart", sawGuess, 0);
        start = 1'b0;
        isSolved = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start_reedge_restart", gameDone, 0);

        // Abort during ISSUE after one scored turn.
        applyStimulus(tbl[14]);
        monEn = 0;
        guessA = '0;
        guessB = '0;
        tick();
        tick();
        if (tbl[14].expAct) guessB = 8'h3C;
        else guessA = 8'h3C;
        tick();
        checkOutput("abort_pre_guess", guessOut, 8'h3C);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_guess_cleared", guessOut, 0);
        checkOutput("abort_score_held", {scoreA, scoreB}, {tbl[14].expA, tbl[14].expB});
        tick();
        tick();
        checkOutput("abort_stays_idle", guessOut, 0);

        // Reset in the middle of RESULT after one scored turn.
        guessA = '0;
        guessB = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        monEn = 1;
        applyStimulus(tbl[15]);
        monEn = 0;
        guessA = '0;
        guessB = '0;
        tick();
        tick();
        if (tbl[15].expAct) guessB = 8'h5C;
        else guessA = 8'h5C;
        tick();
        tick();
        checkOutput("pre_reset_result_guess", guessOut, 8'h5C);
        reset = 1'b0;
        tick();
        checkOutput("reset_mid_guess", guessOut, 0);
        tick();
        checkOutput("reset_mid_active", activePlayer, 0);
        checkOutput("reset_mid_scores", {scoreA, scoreB}, 0);
        checkOutput("reset_mid_flags", {turnTimeout, gameDone, winner}, 0);
        reset = 1'b1;
        tick();
        tick();
        checkOutput("post_reset_idle_guess", guessOut, 0);

        checkOutput("sb_queue_empty", sbQueue.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
